// File: rtl/ts_sched_pkg.sv
// Shared types and constants for the neuron-array timestep scheduler.
// Packet layout: [SRC_MSB:SRC_LSB] source address, [DST_MSB:DST_LSB] destination.
package ts_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DECAY,
      ACCUM
   } state_t;

   localparam int DEF_NUM_NEURONS  = 10;
   localparam int DEF_ADDR_W       = 12;
   localparam int DEF_FIFO_DEPTH   = 8;
   localparam int DEF_ACCUM_CYCLES = 4;

   localparam int SRC_MSB = 2 * DEF_ADDR_W - 1;
   localparam int SRC_LSB = DEF_ADDR_W;
   localparam int DST_MSB = DEF_ADDR_W - 1;
   localparam int DST_LSB = 0;

endpackage

// File: rtl/spike_pkt_fifo.sv
// Synchronous spike-packet buffer with registered count.
// Full is derived from the registered count, so a pop never frees a slot early.
module spike_pkt_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = count == (PW + 1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Packet storage, written at the tail.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally since depth is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/timestep_scheduler.sv
// Timestep sequencer: clear, decay, then a budgeted packet-dispatch window.
// Define TS_DROP_STATS_EN to add the saturating drop_count output.
module timestep_scheduler
   import ts_sched_pkg::*;
#(
   parameter int NUM_NEURONS  = DEF_NUM_NEURONS,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int ACCUM_CYCLES = DEF_ACCUM_CYCLES
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic                            enable,
   input  logic [2*ADDR_W-1:0]             pkt_in,
   input  logic                            pkt_valid,
   output logic                            pkt_ready,
   output logic                            dispatch_valid,
   output logic [$clog2(NUM_NEURONS)-1:0]  dispatch_idx,
   output logic [ADDR_W-1:0]               dispatch_src,
   output logic                            clear,
   output logic                            decay_en,
   output logic                            timestep_done,
   output logic [15:0]                     timestep_count,
   output logic                            busy
`ifdef TS_DROP_STATS_EN
  ,output logic [7:0]                      drop_count
`endif
);

   localparam int IDX_W = $clog2(NUM_NEURONS);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BUD_W = $clog2(ACCUM_CYCLES + 1);
   localparam int WIN_W = (ACCUM_CYCLES > 1) ? $clog2(ACCUM_CYCLES) : 1;

   state_t              state;
   state_t              state_nxt;
   logic [BUD_W-1:0]    budget;
   logic [WIN_W-1:0]    win_cnt;
   logic                win_last;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic [2*ADDR_W-1:0] head;
   logic [ADDR_W-1:0]   head_src;
   logic [ADDR_W-1:0]   head_dst;
   logic                dst_ok;

   assign pkt_ready = !fifo_full;
   assign head_src  = head[SRC_MSB:SRC_LSB];
   assign head_dst  = head[DST_MSB:DST_LSB];
   assign dst_ok    = head_dst < ADDR_W'(NUM_NEURONS);
   assign win_last  = win_cnt == WIN_W'(ACCUM_CYCLES - 1);

   spike_pkt_fifo #(
      .WIDTH (2 * ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .reset (RESET),
      .push  (pkt_valid),
      .din   (pkt_in),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and phase strobes; pops happen only while budget remains.
   always_comb begin
      state_nxt     = state;
      clear         = 1'b0;
      decay_en      = 1'b0;
      timestep_done = 1'b0;
      busy          = 1'b1;
      pop           = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (enable) state_nxt = CLEAR;
         end
         CLEAR: begin
            clear     = 1'b1;
            state_nxt = DECAY;
         end
         DECAY: begin
            decay_en  = 1'b1;
            state_nxt = ACCUM;
         end
         ACCUM: begin
            pop = (budget != '0) && !fifo_empty;
            if (win_last) begin
               timestep_done = 1'b1;
               state_nxt     = enable ? CLEAR : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Budget latch, window counter, timestep count and registered dispatch.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         budget         <= '0;
         win_cnt        <= '0;
         timestep_count <= '0;
         dispatch_valid <= 1'b0;
         dispatch_idx   <= '0;
         dispatch_src   <= '0;
      end else begin
         dispatch_valid <= pop && dst_ok;
         if (pop && dst_ok) begin
            dispatch_idx <= head_dst[IDX_W-1:0];
            dispatch_src <= head_src;
         end
         if (state == DECAY) begin
            if (int'(fifo_count) < ACCUM_CYCLES) budget <= BUD_W'(fifo_count);
            else                                 budget <= BUD_W'(ACCUM_CYCLES);
         end else if (pop) begin
            budget <= budget - BUD_W'(1);
         end
         if (state == ACCUM && !win_last) win_cnt <= win_cnt + WIN_W'(1);
         else                             win_cnt <= '0;
         if (timestep_done) timestep_count <= timestep_count + 16'd1;
      end
   end

`ifdef TS_DROP_STATS_EN
   logic [1:0] drop_inc;
   logic [8:0] drop_sum;

   assign drop_inc = {1'b0, pop && !dst_ok} + {1'b0, pkt_valid && fifo_full};
   assign drop_sum = {1'b0, drop_count} + {7'd0, drop_inc};

   // Saturating count of discarded and stalled packets.
   always_ff @(posedge CLK) begin
      if (RESET)            drop_count <= '0;
      else if (drop_sum[8]) drop_count <= 8'hFF;
      else                  drop_count <= drop_sum[7:0];
   end
`endif

endmodule

// File: doc/timestep_scheduler.md
Name: timestep_scheduler

Overview:
- Sequences one neuron-array timestep: clear pulse, potential-decay phase, then an accumulate window that feeds buffered spike packets to the per-neuron MAC source-address inputs.
- Sits between spike_handle (packet producer) and the mac/potential_decay/potential_adder array.
- Replaces the free-running clock-count clear generation and the unbuffered packet-to-MAC write with a deterministic, back-pressured schedule.

Parameters:
- NUM_NEURONS, 10, neurons in the array; valid destination indices are 0..NUM_NEURONS-1.
- ADDR_W, 12, neuron/source address width; packet width is 2*ADDR_W.
- FIFO_DEPTH, 8, packet buffer entries; must be a power of 2, at least 2.
- ACCUM_CYCLES, 4, length of the accumulate window in cycles; must be at least 1.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- enable  in  1  when 1, timesteps run back-to-back; sampled in IDLE.
- pkt_in  in  2*ADDR_W  [23:12] = source neuron address, [11:0] = destination neuron index.
- pkt_valid  in  1  packet offer.
- pkt_ready  out  1  equals !fifo_full; a transfer occurs when valid && ready.
- dispatch_valid  out  1  one-cycle strobe that loads mac[dispatch_idx].
- dispatch_idx  out  $clog2(NUM_NEURONS)  target MAC index.
- dispatch_src  out  ADDR_W  source address presented to that MAC.
- clear  out  1  timestep clear to mac, potential_decay and potential_adder.
- decay_en  out  1  decay phase strobe.
- timestep_done  out  1  one-cycle pulse on the last ACCUM cycle.
- timestep_count  out  16  completed timesteps; wraps 0xFFFF to 0.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (RESET=1 at a CLK edge, in any state):
  - state = IDLE; FIFO flushed (rd/wr pointers and count = 0); budget = 0.
  - All outputs 0 except pkt_ready = 1.
  - dispatch_idx and dispatch_src = 0.
- States and transitions:
  - IDLE: goes to CLEAR when enable = 1; otherwise stays.
  - CLEAR: 1 cycle, clear = 1. Goes to DECAY.
  - DECAY: 1 cycle, decay_en = 1. On entry to ACCUM, latch budget = min(fifo_count, ACCUM_CYCLES).
  - ACCUM: exactly ACCUM_CYCLES cycles, tracked by a window counter.
  - On the last ACCUM cycle: timestep_done = 1 and timestep_count increments. Next state is CLEAR if enable = 1, else IDLE.
- Dispatch during ACCUM:
  - While budget > 0: pop the FIFO head, drive it to dispatch_idx/dispatch_src with dispatch_valid = 1, decrement budget.
  - At most one dispatch per cycle. Outputs are registered, so dispatch lands one cycle after the pop decision. The final pop must still complete inside the window.
  - Packets enqueued after the budget latch are never dispatched in the current window. They wait for the next timestep, which gives t to t+1 spike propagation semantics.
  - Undispatched remainder stays in the FIFO in order.
- Out-of-range destination:
  - A packet whose pkt_in[11:0] >= NUM_NEURONS is popped and consumes budget, but dispatch_valid stays 0 for that cycle.
- FIFO:
  - Push when pkt_valid && pkt_ready.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - When full, pkt_ready = 0 even if a pop occurs that cycle (no combinational ready-through).
  - Pops never occur when empty, because budget <= count.
- Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
- Dropping enable mid-timestep finishes the current timestep, then returns to IDLE.
- Packets can be accepted in every state, including IDLE.

Optional Feature:
- Macro: TS_DROP_STATS_EN.
- Defined:
  - Adds output drop_count (8 bits, saturating at 255, cleared by RESET).
  - It increments on each popped out-of-range packet, and on each cycle pkt_valid=1 && pkt_ready=0.
- Undefined: port absent, no counter logic. Core behaviour is identical either way.

Decomposition:
- Package ts_sched_pkg holds:
  - state enum {IDLE, CLEAR, DECAY, ACCUM}.
  - Packet field offsets: SRC_MSB/LSB, DST_MSB/LSB.
  - Default parameter constants.
- One sub-module, spike_pkt_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised on width and depth. Instantiated once.

Test Plan:
- Reset then enable=1, no packets:
  - clear high in cycle 1, decay_en in cycle 2, ACCUM cycles 3-6.
  - timestep_done in cycle 6, timestep_count=1, clear again in cycle 7.
- Push {12'd0,12'd3}, {12'd4,12'd6} before CLEAR:
  - ACCUM dispatches idx 3/src 0, then idx 6/src 4, on consecutive cycles.
  - Total dispatch_valid pulses = 2.
- Push 6 packets with ACCUM_CYCLES=4:
  - 4 dispatched in timestep 1, the remaining 2 in timestep 2, order preserved.
- Push during ACCUM after the latch: that packet is not dispatched until the next ACCUM.
- Push 8 packets with enable=0:
  - pkt_ready=0 while full; a 9th valid is not accepted.
  - With TS_DROP_STATS_EN defined, drop_count increments once per stalled cycle.
- Packet with dst=12'd12, and RESET asserted mid-ACCUM:
  - No dispatch_valid for the dst=12'd12 slot.
  - After RESET: FIFO empty, state IDLE, timestep_count=0, pkt_ready=1.
